// File: rtl/blk_loader.sv
// blk_loader: packs an upstream byte stream into SMALL (132 B) or LARGE (768 B) blocks for the encoder FIFOs.
// Optional oversize-block counter is built when BLK_LOADER_ERRCNT_EN is defined.
module blk_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_sop,
  input  logic       in_eop,
  output logic       in_ready,
  output logic [7:0] fifo_w_data,
  output logic       wrreq_data,
  input  logic       full_data,
  output logic [7:0] fifo_w_meta,
  output logic       wrreq_meta,
  input  logic       full_meta,
  output logic       blk_ready,
  input  logic       computation_done,
  output logic       blk_err,
  output logic [7:0] err_count,
  output logic [2:0] o_dbg_state
);

  localparam logic [9:0] SMALL_BYTES = 10'd132;
  localparam logic [9:0] LARGE_BYTES = 10'd768;

  typedef enum logic [2:0] {IDLE, LOAD, PAD, META, READY, WAIT_DONE} state_t;

  state_t     r_state;
  logic [9:0] r_cnt;
  logic       r_large;
  logic       r_oversize;
  logic [7:0] r_meta_code;
  logic       r_blk_ready;
  logic       r_blk_err;

  logic       w_accept;
  logic       w_room;
  logic [9:0] w_cnt_nxt;
  logic       w_fin_large;
  logic [9:0] w_fin_target;
  logic [9:0] w_pad_target;
  state_t     w_end_state;
  logic       w_meta_wr;

  // Handshake: a byte transfers on the rising edge where in_valid & in_ready; in_ready
  // depends on in_* only in IDLE, where an SOP byte is held off while the data FIFO is full.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      IDLE:    in_ready = ~(in_valid & in_sop & full_data);
      LOAD:    in_ready = ~full_data;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign w_room   = (r_cnt != LARGE_BYTES);

  always_comb begin
    wrreq_data  = 1'b0;
    fifo_w_data = 8'h00;
    if (!reset) begin
      case (r_state)
        IDLE: if (w_accept && in_sop) begin
          wrreq_data  = 1'b1;
          fifo_w_data = in_data;
        end
        LOAD: if (w_accept && w_room) begin
          wrreq_data  = 1'b1;
          fifo_w_data = in_data;
        end
        PAD: if (!full_data) begin
          wrreq_data  = 1'b1;
          fifo_w_data = 8'h00;
        end
        default: begin
          wrreq_data  = 1'b0;
          fifo_w_data = 8'h00;
        end
      endcase
    end
  end

  // Byte count after the byte on the input, which is dropped once the block holds 768 bytes.
  assign w_cnt_nxt    = (r_state == IDLE) ? 10'd1 : (w_room ? r_cnt + 10'd1 : r_cnt);
  assign w_fin_large  = (w_cnt_nxt > SMALL_BYTES);
  assign w_fin_target = w_fin_large ? LARGE_BYTES : SMALL_BYTES;
  assign w_end_state  = (w_cnt_nxt == w_fin_target) ? META : PAD;
  assign w_pad_target = r_large ? LARGE_BYTES : SMALL_BYTES;

  // The meta strobe is decoded from registered state and gated by full_meta, so it can
  // never fire into a full FIFO and the state only advances when the write really happens.
  assign w_meta_wr   = (r_state == META) && !full_meta;
  assign wrreq_meta  = w_meta_wr;
  assign fifo_w_meta = r_meta_code;
  assign blk_ready   = r_blk_ready;
  assign blk_err     = r_blk_err;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 10'd0;
      r_large     <= 1'b0;
      r_oversize  <= 1'b0;
      r_meta_code <= 8'h00;
      r_blk_ready <= 1'b0;
      r_blk_err   <= 1'b0;
    end else begin
      r_blk_ready <= 1'b0;
      r_blk_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && in_sop) begin
            r_cnt      <= w_cnt_nxt;
            r_oversize <= 1'b0;
            if (in_eop) begin
              r_large     <= w_fin_large;
              r_meta_code <= {7'd0, w_fin_large};
              r_state     <= w_end_state;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (!w_room) r_oversize <= 1'b1;
            if (in_eop) begin
              r_large     <= w_fin_large;
              r_meta_code <= {7'd0, w_fin_large};
              r_state     <= w_end_state;
            end
          end
        end
        PAD: begin
          if (!full_data) begin
            r_cnt <= r_cnt + 10'd1;
            if ((r_cnt + 10'd1) == w_pad_target) r_state <= META;
          end
        end
        META: begin
          if (w_meta_wr) begin
            r_blk_ready <= 1'b1;
            r_blk_err   <= r_oversize;
            r_state     <= READY;
          end
        end
        READY: r_state <= WAIT_DONE;
        WAIT_DONE: begin
          if (computation_done) begin
            r_cnt   <= 10'd0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef BLK_LOADER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= 8'h00;
    end else if (w_meta_wr && r_oversize && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_blk_loader.sv
// Bench for blk_loader: block-level reference model feeds expected queues; a monitor checks FIFO writes and block events.
module tb_blk_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_eop;
  logic       in_ready;
  logic [7:0] fifo_w_data;
  logic       wrreq_data;
  logic       full_data;
  logic [7:0] fifo_w_meta;
  logic       wrreq_meta;
  logic       full_meta;
  logic       blk_ready;
  logic       computation_done;
  logic       blk_err;
  logic [7:0] err_count;
  logic [2:0] dbg_state;

  blk_loader dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_sop           (in_sop),
    .in_eop           (in_eop),
    .in_ready         (in_ready),
    .fifo_w_data      (fifo_w_data),
    .wrreq_data       (wrreq_data),
    .full_data        (full_data),
    .fifo_w_meta      (fifo_w_meta),
    .wrreq_meta       (wrreq_meta),
    .full_meta        (full_meta),
    .blk_ready        (blk_ready),
    .computation_done (computation_done),
    .blk_err          (blk_err),
    .err_count        (err_count),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_meta_q[$];
  logic [8:0] exp_blk_q[$];
  logic [7:0] blk_bytes[$];
  int         mdl_err = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  bit         abort_run = 0;
  bit         busy = 0;
  bit         lat_armed = 0;
  int         eop_cyc = 0;
  int         hold_data = 0;
  bit         full_rand = 0;
  bit         meta_rand = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a block of n bytes keeps min(n,768) bytes, is zero-filled to the
  // smallest of 132/768 that holds them, and flags an error when bytes were dropped.
  task automatic model_push();
    int n;
    int kept;
    int tgt;
    logic [7:0] cnt_exp;
    n    = blk_bytes.size();
    kept = (n > 768) ? 768 : n;
    tgt  = (kept <= 132) ? 132 : 768;
    for (int i = 0; i < kept; i++) exp_q.push_back(blk_bytes[i]);
    for (int i = kept; i < tgt; i++) exp_q.push_back(8'h00);
    exp_meta_q.push_back((tgt == 768) ? 8'd1 : 8'd0);
    if (n > 768 && mdl_err < 255) mdl_err++;
`ifdef BLK_LOADER_ERRCNT_EN
    cnt_exp = mdl_err[7:0];
`else
    cnt_exp = 8'h00;
`endif
    exp_blk_q.push_back({(n > 768) ? 1'b1 : 1'b0, cnt_exp});
  endtask

  task automatic make_block(input int n, input bit rnd);
    blk_bytes.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
      blk_bytes.push_back(b);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic put_byte(input logic [7:0] d, input logic s, input logic e, output bit ok);
    int guard;
    bit acc;
    guard = 0;
    ok = 0;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    while (guard < 4000) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && e) eop_cyc = cyc;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1;
        break;
      end
      guard++;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!ok) chk("accept_timeout", in_ready, 1);
  endtask

  task automatic send_block(input int abort_at, input int hold_at, input bit rand_sop);
    int n;
    bit ok;
    logic s;
    n = blk_bytes.size();
    for (int i = 0; i < n; i++) begin
      if (abort_run) return;
      if (i == hold_at) begin
        hold_data = 5;
        @(posedge clk); #2;
        @(negedge clk);
        chk("load_rdy_when_full", in_ready, 0);
        chk("load_wr_when_full", wrreq_data, 0);
        @(posedge clk); #1;
      end
      s = (i == 0) || (rand_sop && ($urandom_range(0, 15) == 0));
      put_byte(blk_bytes[i], s, (i == n - 1), ok);
      if (!ok) begin
        abort_run = 1;
        return;
      end
      if (abort_at == i + 1) return;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || exp_meta_q.size() != 0 || exp_blk_q.size() != 0 || busy) && g < 6000) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (g >= 6000) begin
      chk("idle_timeout_q", exp_q.size(), 0);
      abort_run = 1;
    end
  endtask

  // FIFO full stimulus: directed holds or random back-pressure.
  initial begin
    full_data = 1'b0;
    full_meta = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_data > 0) begin
        full_data = 1'b1;
        hold_data--;
      end else begin
        full_data = full_rand && ($urandom_range(0, 3) == 0);
      end
      full_meta = meta_rand && ($urandom_range(0, 2) == 0);
    end
  end

  // Encoder stand-in: acknowledges each block after a random delay, and occasionally
  // pulses computation_done at times the loader must ignore.
  initial begin
    computation_done = 1'b0;
    forever begin
      @(negedge clk);
      computation_done = 1'b0;
      if (blk_ready) begin
        busy = 1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 computation_done = 1'b1;
        @(posedge clk);
        #1 computation_done = 1'b0;
        busy = 0;
      end else if (!reset && $urandom_range(0, 40) == 0) begin
        computation_done = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [8:0] mon_blk;

  always @(negedge clk) begin
    if (!reset) begin
      if (wrreq_data) begin
        chk("data_wr_while_full", full_data, 0);
        chk("data_wr_while_waiting", busy, 0);
        if (exp_q.size() != 0) chk("data_byte", fifo_w_data, exp_q.pop_front());
        else chk("data_unexpected_write", wrreq_data, 0);
      end
      if (wrreq_meta) begin
        chk("meta_wr_while_full", full_meta, 0);
        if (lat_armed) chk("meta_latency", cyc - eop_cyc, 1);
        if (exp_meta_q.size() != 0) chk("meta_code", fifo_w_meta, exp_meta_q.pop_front());
        else chk("meta_unexpected_write", wrreq_meta, 0);
      end
      if (blk_ready) begin
        if (lat_armed) begin
          chk("ready_latency", cyc - eop_cyc, 2);
          lat_armed = 0;
        end
        if (exp_blk_q.size() != 0) begin
          mon_blk = exp_blk_q.pop_front();
          chk("blk_err", blk_err, mon_blk[8]);
          chk("err_count", err_count, mon_blk[7:0]);
        end else begin
          chk("blk_ready_unexpected", blk_ready, 0);
        end
      end else if (blk_err) begin
        chk("blk_err_without_ready", blk_err, 0);
      end
      if (busy) chk("in_ready_while_waiting", in_ready, 0);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int sz_tab[8];
    sz_tab = '{1, 131, 132, 133, 767, 768, 769, 5};
    reset = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_sop = 1'b0; in_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wrreq_data", wrreq_data, 0);
    chk("rst_wrreq_meta", wrreq_meta, 0);
    chk("rst_blk_ready", blk_ready, 0);
    chk("rst_blk_err", blk_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_fifo_w_meta", fifo_w_meta, 0);
    @(posedge clk); #1;

    // Exact SMALL block 0x01..0x84 with latency check.
    make_block(132, 0);
    model_push();
    lat_armed = 1;
    send_block(0, -1, 0);
    wait_idle();

    // Bytes without SOP in IDLE are swallowed.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA0 + i); in_sop = 1'b0; in_eop = (i == 2);
      @(negedge clk);
      chk("idle_discard_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_eop = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Padding and oversize cases.
    make_block(10, 1);  model_push(); send_block(0, -1, 0); wait_idle();
    make_block(200, 1); model_push(); send_block(0, -1, 1); wait_idle();
    make_block(800, 1); model_push(); send_block(0, -1, 1); wait_idle();

    // Back-pressure held mid-PAD, then mid-LOAD.
    make_block(10, 1); model_push(); send_block(0, -1, 0);
    repeat (10) @(posedge clk);
    #1 hold_data = 5;
    @(posedge clk); #2;
    @(negedge clk);
    chk("pad_rdy_when_full", in_ready, 0);
    chk("pad_wr_when_full", wrreq_data, 0);
    wait_idle();
    make_block(300, 1); model_push(); send_block(0, 100, 0); wait_idle();

    // Asynchronous reset in the middle of a block at cnt=50.
    make_block(100, 1); model_push(); send_block(50, -1, 0);
    in_valid = 1'b1; in_data = 8'h55; in_sop = 1'b0; in_eop = 1'b0;
    #3 reset = 1'b1;
    exp_q.delete(); exp_meta_q.delete(); exp_blk_q.delete();
    mdl_err = 0;
    #1;
    chk("arst_wrreq_data", wrreq_data, 0);
    chk("arst_fifo_w_data", fifo_w_data, 0);
    chk("arst_wrreq_meta", wrreq_meta, 0);
    chk("arst_fifo_w_meta", fifo_w_meta, 0);
    chk("arst_blk_ready", blk_ready, 0);
    chk("arst_blk_err", blk_err, 0);
    chk("arst_err_count", err_count, 0);
    in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    make_block(20, 1); model_push(); send_block(0, -1, 0); wait_idle();

    // Randomized blocks, back-to-back, with random FIFO back-pressure.
    full_rand = 1;
    meta_rand = 1;
    for (int b = 0; b < 14 && !abort_run; b++) begin
      int n;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 900)) : sz_tab[$urandom_range(0, 7)];
      make_block(n, 1);
      model_push();
      send_block(0, -1, 1);
    end
    wait_idle();
    full_rand = 0;
    meta_rand = 0;

    chk("final_data_q_empty", exp_q.size(), 0);
    chk("final_meta_q_empty", exp_meta_q.size(), 0);
    chk("final_blk_q_empty", exp_blk_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
